// File: rtl/ex_wb_stage.sv
// EX->WB pipeline register: owns the Z/CY flags, the WB-to-EX forwarding compare
// and the retired-instruction counter.
module ex_wb_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_wr_en,
  input  logic              ex_flag_en,
  input  logic              ex_flag_set,
  input  logic [1:0]        ex_flag_val,
  input  logic [DATA_W-1:0] alu_y,
  input  logic              alu_z,
  input  logic              alu_cy,
  input  logic              stall,
  input  logic              flush,
  output logic              flag_z,
  output logic              flag_cy,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] fwd_rs_a,
  input  logic [REG_AW-1:0] fwd_rs_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [15:0]       retired_cnt
);

  logic              w_capture;
  logic              r_valid, r_we, r_z, r_cy;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_data;
  logic [15:0]       r_cnt;

  // Stall and flush both turn the EX slot into a bubble.
  assign w_capture = ex_valid & ~stall & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_rd    <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_we    <= ex_wr_en;
      r_rd    <= ex_rd;
      r_data  <= alu_y;
      r_cnt   <= r_cnt + 16'd1;
    end else begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end
  end

  // Explicit flag loads take priority over ALU-generated flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_z  <= 1'b0;
      r_cy <= 1'b0;
    end else if (w_capture) begin
      if (ex_flag_set) begin
        r_z  <= ex_flag_val[1];
        r_cy <= ex_flag_val[0];
      end else if (ex_flag_en) begin
        r_z  <= alu_z;
        r_cy <= alu_cy;
      end
    end
  end

  assign flag_z      = r_z;
  assign flag_cy     = r_cy;
  assign wb_valid    = r_valid;
  assign wb_we       = r_we;
  assign wb_rd       = r_rd;
  assign wb_data     = r_data;
  assign retired_cnt = r_cnt;

  // Compare against registered state only; R0 is an ordinary register here.
  assign fwd_a_hit = r_we & (fwd_rs_a == r_rd);
  assign fwd_b_hit = r_we & (fwd_rs_b == r_rd);

endmodule
